// File: rtl/masked_gadget_scheduler.sv
// masked_gadget_scheduler
// Round-robin issue controller for one shared, fixed-latency masked gadget.
// Issues at most one operation per cycle, only when a fresh randomness word
// is available, and returns a one-hot response strobe LAT cycles after issue.
// Carries no share data: it only drives mux selects and strobes.
// Optional macro ISSUE_GAP_EN: forces an idle cycle after every issue.
module masked_gadget_scheduler #(
  parameter int N       = 4,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2
) (
  input  logic         C,
  input  logic         R,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] ack,
  output logic [N-1:0] gnt,
  output logic         g_go,
  input  logic         rnd_valid,
  output logic         rnd_take,
  output logic [N-1:0] rsp_valid,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Tag pipeline, index 0 is stage 1, index LAT-1 is the completing stage
  logic          tag_vld_q [LAT];
  logic          tag_vld_d [LAT];
  logic [IW-1:0] tag_idx_q [LAT];
  logic [IW-1:0] tag_idx_d [LAT];

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          issue;
  logic          done;

  assign done = tag_vld_q[LAT-1];

`ifdef ISSUE_GAP_EN
  logic gap_q, gap_d;

  // Remember that the previous cycle issued so this cycle stays quiet
  always_comb begin
    gap_d = issue;
  end

  // Gap flag register
  always_ff @(posedge C or posedge R) begin
    if (R) gap_q <= 1'b0;
    else   gap_q <= gap_d;
  end
`endif

  // Round-robin pick: first set req scanning ptr+1, ptr+2, ... mod N
  always_comb begin
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    // Walk from the farthest offset down so the nearest one wins last
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Issue decision; a completion this cycle frees a slot at cnt == MAX_OUT
  always_comb begin
    issue = !R && en && (state_q != ST_DRAIN) && win_found && rnd_valid &&
            ((cnt_q < CW'(MAX_OUT)) || done);
`ifdef ISSUE_GAP_EN
    issue = issue && !gap_q;
`endif
  end

  // Next-state logic: FSM, pointer, occupancy counter
  always_comb begin
    ptr_d = issue ? win_idx : ptr_q;
    cnt_d = cnt_q;
    if (issue && !done)      cnt_d = cnt_q + CW'(1);
    else if (!issue && done) cnt_d = cnt_q - CW'(1);

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = (cnt_d != '0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (en)                 state_d = ST_RUN;
        else if (cnt_d == '0)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag pipeline shift: new issue enters stage 1, others advance one stage
  always_comb begin
    tag_vld_d[0] = issue;
    tag_idx_d[0] = win_idx;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  // Control state register; ptr resets to N-1 so requester 0 goes first
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      // One tag stage; reset drops every in-flight operation
      always_ff @(posedge C or posedge R) begin
        if (R) begin
          tag_vld_q[gi] <= 1'b0;
          tag_idx_q[gi] <= '0;
        end else begin
          tag_vld_q[gi] <= tag_vld_d[gi];
          tag_idx_q[gi] <= tag_idx_d[gi];
        end
      end
    end
  endgenerate

  // Outputs: Mealy issue strobes plus registered response decode
  always_comb begin
    ack       = issue ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
    gnt       = ack;
    g_go      = issue;
    rnd_take  = issue;
    rsp_valid = done ? ({{(N-1){1'b0}}, 1'b1} << tag_idx_q[LAT-1]) : '0;
    busy      = (state_q != ST_IDLE);
  end

endmodule
